// File: rtl/sdram_pkg.sv
// Shared widths, page geometry and FSM state type for the SDRAM write streamer.
// SDRAM_WR_PAGE_WRAP_EN (optional) is consumed by the top, not by this package.
package sdram_pkg;

  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned LEN_W      = 9;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned PAGE_WORDS = 512;
  localparam int unsigned MAX_BURST  = 256;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER,
    DRAIN
  } state_t;

endpackage

// File: rtl/sdram_wr_fifo.sv
// Synchronous show-ahead FIFO; rdata is the head word whenever not empty.
module sdram_wr_fifo
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [9:0]        level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == 10'(DEPTH));
  assign empty   = (level == '0);
  // A push at full is refused even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 10'd1;
        2'b01:   level <= level - 10'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/sdram_wr_streamer.sv
// Buffers a 16-bit stream and issues SDRAM write bursts at a rolling address.
// Optional macro SDRAM_WR_PAGE_WRAP_EN: clip bursts at 512-word page boundaries.
module sdram_wr_streamer
  import sdram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned BURST_THR  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] S_DATA,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic              FLUSH,
  input  logic              ADDR_LOAD,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic              BUSY,
  input  logic              WR_ADV,
  input  logic [LEN_W-1:0]  MAX_LEN,
  output logic              REQUEST,
  output logic              WRITE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [LEN_W-1:0]  LENGTH,
  output logic [DATA_W-1:0] DATA_IN,
  output logic [9:0]        LEVEL,
  output logic              ERR
);

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [LEN_W-1:0]  popped;
  logic              flush_pend;
  logic              full;
  logic              empty;
  logic              pop;
  logic              wr_err;
  logic              trig;
  logic [9:0]        len_c;
`ifdef SDRAM_WR_PAGE_WRAP_EN
  logic [9:0]        page_room;
`endif

  sdram_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (S_VALID),
    .pop   (pop),
    .wdata (S_DATA),
    .rdata (DATA_IN),
    .full  (full),
    .empty (empty),
    .level (LEVEL)
  );

  assign S_READY = !full;
  assign pop     = WR_ADV && (state == XFER) && !empty;
  assign wr_err  = WR_ADV && !((state == XFER) && !empty);
  assign trig    = !BUSY && ((LEVEL >= 10'(BURST_THR)) || (flush_pend && (LEVEL != '0)));

  always_comb begin
    len_c = LEVEL;
    if (len_c > 10'(BURST_THR))  len_c = 10'(BURST_THR);
    if (len_c > {1'b0, MAX_LEN}) len_c = {1'b0, MAX_LEN};
    if (len_c > 10'(MAX_BURST))  len_c = 10'(MAX_BURST);
`ifdef SDRAM_WR_PAGE_WRAP_EN
    page_room = 10'(PAGE_WORDS) - {1'b0, wptr[8:0]};
    if (len_c > page_room) len_c = page_room;
`endif
    // A zero MAX_LEN still moves one word so the pipe cannot stall.
    if (len_c == '0) len_c = 10'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      REQUEST    <= 1'b0;
      WRITE      <= 1'b0;
      ADDR       <= '0;
      LENGTH     <= '0;
      ERR        <= 1'b0;
      flush_pend <= 1'b0;
      wptr       <= '0;
      popped     <= '0;
    end else begin
      if (wr_err) ERR <= 1'b1;

      if (FLUSH)
        flush_pend <= 1'b1;
      else if ((state == IDLE) && (LEVEL == '0))
        flush_pend <= 1'b0;

      case (state)
        IDLE: begin
          // An address load defers any trigger by one cycle.
          if (ADDR_LOAD) begin
            wptr <= BASE_ADDR;
          end else if (trig) begin
            state   <= ISSUE;
            REQUEST <= 1'b1;
            WRITE   <= 1'b1;
            ADDR    <= wptr;
            LENGTH  <= len_c[LEN_W-1:0];
            popped  <= '0;
          end
        end
        ISSUE: begin
          REQUEST <= 1'b0;
          state   <= XFER;
        end
        XFER: begin
          if (pop) begin
            popped <= popped + 9'd1;
            if (popped + 9'd1 == LENGTH) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!BUSY) begin
            wptr  <= wptr + {{(ADDR_W-LEN_W){1'b0}}, LENGTH};
            WRITE <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wr_streamer.sv
// Randomised self-checking bench for sdram_wr_streamer against a queue model.
module tb_sdram_wr_streamer;

  localparam int THR   = 8;
  localparam int DEPTH = 512;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] S_DATA;
  logic        S_VALID;
  logic        S_READY;
  logic        FLUSH;
  logic        ADDR_LOAD;
  logic [23:0] BASE_ADDR;
  logic        BUSY;
  logic        WR_ADV;
  logic [8:0]  MAX_LEN;
  logic        REQUEST;
  logic        WRITE;
  logic [23:0] ADDR;
  logic [8:0]  LENGTH;
  logic [15:0] DATA_IN;
  logic [9:0]  LEVEL;
  logic        ERR;

  int checks = 0;
  int failures = 0;
  logic [15:0] q[$];
  int unsigned ptr_m;

  sdram_wr_streamer #(
    .FIFO_DEPTH(DEPTH),
    .BURST_THR (THR)
  ) dut (
    .CLK(CLK), .RESET(RESET), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .FLUSH(FLUSH), .ADDR_LOAD(ADDR_LOAD), .BASE_ADDR(BASE_ADDR), .BUSY(BUSY),
    .WR_ADV(WR_ADV), .MAX_LEN(MAX_LEN), .REQUEST(REQUEST), .WRITE(WRITE),
    .ADDR(ADDR), .LENGTH(LENGTH), .DATA_IN(DATA_IN), .LEVEL(LEVEL), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic int exp_len(int lvl, int ml, int unsigned p);
    int l;
    l = lvl;
    if (l > THR) l = THR;
    if (l > ml)  l = ml;
    if (l > 256) l = 256;
`ifdef SDRAM_WR_PAGE_WRAP_EN
    if (l > 512 - int'(p % 512)) l = 512 - int'(p % 512);
`endif
    if (l < 1) l = 1;
    return l;
  endfunction

  task automatic do_reset();
    RESET = 1'b1; S_VALID = 1'b0; S_DATA = '0; FLUSH = 1'b0; ADDR_LOAD = 1'b0;
    BASE_ADDR = '0; BUSY = 1'b0; WR_ADV = 1'b0; MAX_LEN = 9'd256;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    q.delete();
    ptr_m = 0;
  endtask

  task automatic load_addr(input logic [23:0] a);
    BASE_ADDR = a; ADDR_LOAD = 1'b1;
    @(negedge CLK);
    ADDR_LOAD = 1'b0;
    ptr_m = a;
  endtask

  task automatic push_words(input int n, input bit seq);
    bit exp_rdy;
    for (int i = 0; i < n; i++) begin
      S_VALID = 1'b1;
      S_DATA  = seq ? 16'(i + 1) : 16'($urandom);
      exp_rdy = (q.size() < DEPTH);
      checks++;
      if (S_READY !== exp_rdy) begin
        failures++;
        $display("FAIL s_ready got=%b want=%b", S_READY, exp_rdy);
      end
      if (exp_rdy) q.push_back(S_DATA);
      @(negedge CLK);
    end
    S_VALID = 1'b0;
  endtask

  task automatic pulse_flush();
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
  endtask

  task automatic service(input string tag, input int max_bursts);
    int nb, wn, el;
    nb = 0;
    while (q.size() > 0 && nb < max_bursts) begin
      wn = 0;
      while (REQUEST !== 1'b1 && wn < 40) begin @(negedge CLK); wn++; end
      checks++;
      if (REQUEST !== 1'b1) begin
        failures++;
        $display("FAIL %s request_timeout got=%b want=1", tag, REQUEST);
        return;
      end
      el = exp_len(q.size(), int'(MAX_LEN), ptr_m);
      checks += 3;
      if (ADDR !== ptr_m[23:0]) begin
        failures++; $display("FAIL %s addr got=%h want=%h", tag, ADDR, ptr_m[23:0]);
      end
      if (LENGTH !== 9'(el)) begin
        failures++; $display("FAIL %s length got=%0d want=%0d", tag, LENGTH, el);
      end
      if (WRITE !== 1'b1) begin
        failures++; $display("FAIL %s write got=%b want=1", tag, WRITE);
      end
      @(negedge CLK);
      for (int k = 0; k < el; k++) begin
        WR_ADV = 1'b1;
        checks++;
        if (q.size() == 0 || DATA_IN !== q[0]) begin
          failures++;
          $display("FAIL %s data_in k=%0d got=%h want=%h", tag, k, DATA_IN, (q.size() > 0) ? q[0] : 16'hxxxx);
        end
        if (q.size() > 0) void'(q.pop_front());
        @(negedge CLK);
      end
      WR_ADV = 1'b0;
      ptr_m = (ptr_m + el) % (1 << 24);
      @(negedge CLK);
      checks += 2;
      if (WRITE !== 1'b0 || REQUEST !== 1'b0) begin
        failures++; $display("FAIL %s post_burst write=%b req=%b want=0/0", tag, WRITE, REQUEST);
      end
      if (ERR !== 1'b0) begin
        failures++; $display("FAIL %s err got=%b want=0", tag, ERR);
      end
      nb++;
    end
  endtask

  task automatic expect_quiet(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (REQUEST !== 1'b0) seen = 1'b1;
      @(negedge CLK);
    end
    checks += 2;
    if (seen) begin failures++; $display("FAIL %s spurious_request got=1 want=0", tag); end
    if (LEVEL !== 10'(q.size())) begin
      failures++; $display("FAIL %s level got=%0d want=%0d", tag, LEVEL, q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (REQUEST !== 1'b0) begin failures++; $display("FAIL rst_request got=%b want=0", REQUEST); end
    if (WRITE !== 1'b0)   begin failures++; $display("FAIL rst_write got=%b want=0", WRITE); end
    if (ADDR !== 24'h0)   begin failures++; $display("FAIL rst_addr got=%h want=0", ADDR); end
    if (LENGTH !== 9'h0)  begin failures++; $display("FAIL rst_length got=%0d want=0", LENGTH); end
    if (LEVEL !== 10'h0)  begin failures++; $display("FAIL rst_level got=%0d want=0", LEVEL); end
    if (ERR !== 1'b0)     begin failures++; $display("FAIL rst_err got=%b want=0", ERR); end
    if (S_READY !== 1'b1) begin failures++; $display("FAIL rst_s_ready got=%b want=1", S_READY); end
  endtask

  task automatic test_basic();
    do_reset();
    load_addr(24'h00425B);
    push_words(8, 1'b1);
    service("basic", 1);
    push_words(1, 1'b0);
    pulse_flush();
    service("basic_next_ptr", 1);
  endtask

  task automatic test_flush();
    do_reset();
    push_words(3, 1'b0);
    pulse_flush();
    service("flush", 4);
    expect_quiet("flush_after");
    pulse_flush();
    expect_quiet("flush_empty");
  endtask

  task automatic test_max_len();
    do_reset();
    MAX_LEN = 9'd4;
    BUSY = 1'b1;
    push_words(8, 1'b0);
    BUSY = 1'b0;
    pulse_flush();
    service("max_len", 4);
    expect_quiet("max_len_after");
    MAX_LEN = 9'd256;
  endtask

  task automatic test_page();
    do_reset();
    load_addr(24'h0001FC);
    BUSY = 1'b1;
    push_words(8, 1'b0);
    BUSY = 1'b0;
    pulse_flush();
    service("page", 4);
  endtask

  task automatic test_wrap();
    do_reset();
    load_addr(24'hFFFFFC);
    BUSY = 1'b1;
    push_words(8, 1'b0);
    BUSY = 1'b0;
    pulse_flush();
    service("wrap", 4);
    push_words(1, 1'b0);
    pulse_flush();
    service("wrap_next", 1);
  endtask

  task automatic test_load_vs_trigger();
    logic [23:0] a;
    do_reset();
    push_words(8, 1'b0);
    a = 24'($urandom);
    BASE_ADDR = a; ADDR_LOAD = 1'b1;
    @(negedge CLK);
    ADDR_LOAD = 1'b0;
    ptr_m = a;
    checks++;
    if (REQUEST !== 1'b0) begin failures++; $display("FAIL load_wins request got=%b want=0", REQUEST); end
    service("load_vs_trigger", 1);
  endtask

  task automatic test_random();
    int n;
    do_reset();
    load_addr(24'($urandom));
    for (int it = 0; it < 6; it++) begin
      MAX_LEN = 9'($urandom_range(0, 12));
      n = $urandom_range(1, 40);
      BUSY = 1'b1;
      push_words(n, 1'b0);
      checks++;
      if (LEVEL !== 10'(q.size())) begin
        failures++; $display("FAIL rand_level it=%0d got=%0d want=%0d", it, LEVEL, q.size());
      end
      BUSY = 1'b0;
      pulse_flush();
      service("random", 64);
    end
    MAX_LEN = 9'd256;
  endtask

  task automatic test_push_pop();
    int wn, lvl;
    do_reset();
    BUSY = 1'b1;
    push_words(8, 1'b0);
    BUSY = 1'b0;
    wn = 0;
    while (REQUEST !== 1'b1 && wn < 40) begin @(negedge CLK); wn++; end
    checks++;
    if (REQUEST !== 1'b1) begin
      failures++; $display("FAIL pushpop request_timeout got=%b want=1", REQUEST);
      return;
    end
    @(negedge CLK);
    lvl = 8;
    for (int k = 0; k < 8; k++) begin
      WR_ADV  = 1'b1;
      S_VALID = (k < 4);
      S_DATA  = 16'($urandom);
      checks += 2;
      if (LEVEL !== 10'(lvl)) begin
        failures++; $display("FAIL pushpop level k=%0d got=%0d want=%0d", k, LEVEL, lvl);
      end
      if (DATA_IN !== q[0]) begin
        failures++; $display("FAIL pushpop data_in k=%0d got=%h want=%h", k, DATA_IN, q[0]);
      end
      void'(q.pop_front());
      if (k < 4) q.push_back(S_DATA);
      else lvl--;
      @(negedge CLK);
    end
    WR_ADV = 1'b0; S_VALID = 1'b0;
    ptr_m = (ptr_m + 8) % (1 << 24);
    @(negedge CLK);
    pulse_flush();
    service("pushpop_rest", 4);
  endtask

  task automatic test_full();
    do_reset();
    BUSY = 1'b1;
    push_words(DEPTH + 3, 1'b0);
    checks += 2;
    if (LEVEL !== 10'(DEPTH)) begin failures++; $display("FAIL full_level got=%0d want=%0d", LEVEL, DEPTH); end
    if (S_READY !== 1'b0) begin failures++; $display("FAIL full_s_ready got=%b want=0", S_READY); end
    BUSY = 1'b0;
    pulse_flush();
    service("full_drain", 80);
  endtask

  task automatic test_reset_mid();
    int wn;
    do_reset();
    BUSY = 1'b1;
    push_words(8, 1'b0);
    BUSY = 1'b0;
    wn = 0;
    while (REQUEST !== 1'b1 && wn < 40) begin @(negedge CLK); wn++; end
    @(negedge CLK);
    WR_ADV = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    WR_ADV = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    q.delete();
    ptr_m = 0;
    checks += 4;
    if (REQUEST !== 1'b0) begin failures++; $display("FAIL mid_rst_request got=%b want=0", REQUEST); end
    if (LEVEL !== 10'h0)  begin failures++; $display("FAIL mid_rst_level got=%0d want=0", LEVEL); end
    if (ERR !== 1'b0)     begin failures++; $display("FAIL mid_rst_err got=%b want=0", ERR); end
    if (WRITE !== 1'b0)   begin failures++; $display("FAIL mid_rst_write got=%b want=0", WRITE); end
    expect_quiet("mid_rst_quiet");
  endtask

  task automatic test_err();
    do_reset();
    BUSY = 1'b1;
    push_words(3, 1'b0);
    WR_ADV = 1'b1;
    @(negedge CLK);
    WR_ADV = 1'b0;
    @(negedge CLK);
    checks += 2;
    if (ERR !== 1'b1)     begin failures++; $display("FAIL err_idle got=%b want=1", ERR); end
    if (LEVEL !== 10'd3)  begin failures++; $display("FAIL err_level got=%0d want=3", LEVEL); end
    BUSY = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_max_len();
    test_page();
    test_wrap();
    test_load_vs_trigger();
    test_push_pop();
    test_random();
    test_full();
    test_reset_mid();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_wr_streamer.md
SDRAM_WR_STREAMER -- requirements
Module: sdram_wr_streamer

Interface
REQ-001 Parameters SHALL be:
- FIFO_DEPTH, default 512: words buffered; power of two.
- BURST_THR, default 8: fill level that triggers a write burst; 1..256.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK in 1: single clock, all logic on the rising edge.
- RESET in 1: synchronous, active-high.
- S_DATA in 16: stream word.
- S_VALID in 1: S_DATA valid.
- S_READY out 1: word accepted when S_VALID and S_READY are both high.
- FLUSH in 1: one-cycle pulse; drain residual words.
- ADDR_LOAD in 1: load BASE_ADDR into the write pointer.
- BASE_ADDR in 24: word address.
- BUSY in 1: controller busy.
- WR_ADV in 1: controller consumes DATA_IN this cycle.
- MAX_LEN in 9: controller burst cap in words.
- REQUEST out 1: one-cycle burst request.
- WRITE out 1: tied 1 while a request is outstanding, else 0.
- ADDR out 24: burst start word address.
- LENGTH out 9: burst word count.
- DATA_IN out 16: FIFO head word, show-ahead.
- LEVEL out 10: FIFO occupancy.
- ERR out 1: sticky protocol error.

Function
REQ-003 The FIFO SHALL drive S_READY = (LEVEL < FIFO_DEPTH); a push at full is not accepted, even when a pop occurs in the same cycle.
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, XFER, DRAIN.
REQ-005 In IDLE with BUSY low, the block SHALL go to ISSUE when LEVEL >= BURST_THR, or when flush is pending and LEVEL > 0.
REQ-006 ISSUE SHALL:
- assert REQUEST for exactly one cycle;
- drive WRITE=1;
- drive ADDR = write pointer;
- drive LENGTH = min(LEVEL, BURST_THR, MAX_LEN, 256), never 0.
REQ-007 ADDR, LENGTH and WRITE SHALL stay stable from the ISSUE cycle until the block returns to IDLE.
REQ-008 After ISSUE the block SHALL enter XFER. Each cycle with WR_ADV high pops one word. DATA_IN SHALL be valid combinationally from the FIFO head, with zero-cycle latency.
REQ-009 When LENGTH words have been popped, the block SHALL enter DRAIN.
REQ-010 In DRAIN, once BUSY is seen low, the block SHALL:
- add LENGTH to the write pointer, modulo 2^24 (wrap 0xFFFFFF to 0x000000);
- return to IDLE.
REQ-011 WR_ADV outside XFER, or WR_ADV while the FIFO is empty, SHALL set ERR and pop nothing.
REQ-012 A FLUSH pulse SHALL set flush-pending. Flush-pending SHALL clear in IDLE when LEVEL = 0. FLUSH with an empty FIFO SHALL issue no request.
REQ-013 ADDR_LOAD SHALL take effect only in IDLE and is ignored in every other state. If ADDR_LOAD and a trigger occur in the same cycle, the load wins; the request is issued the next cycle with the new address.
REQ-014 Push and pop in the same cycle SHALL leave LEVEL unchanged.

Reset
REQ-015 While RESET is high on a clock edge, the block SHALL set:
- FSM to IDLE; FIFO emptied; LEVEL = 0;
- REQUEST = 0, WRITE = 0, ADDR = 0, LENGTH = 0, ERR = 0;
- flush-pending = 0; write pointer = 0.
REQ-016 RESET SHALL behave identically when asserted mid-burst; undelivered words are discarded.

Configuration
REQ-017 With SDRAM_WR_PAGE_WRAP_EN defined, LENGTH SHALL additionally be clipped to 512 - ADDR[8:0], so no burst crosses a 512-word column page. Without the macro, no page clipping is applied.

Structure
REQ-018 Package sdram_pkg SHALL hold:
- the address width (24), length width (9) and data width (16) constants;
- the page size constant (512);
- the FSM state enum.
REQ-019 The FIFO SHALL be the sub-module sdram_wr_fifo: synchronous, show-ahead, with push, pop, full, empty and level.

Verification
REQ-020 BASE_ADDR=0x00425B with ADDR_LOAD, then push 8 words 0x0001..0x0008 -> one REQUEST with ADDR=0x00425B, LENGTH=8; DATA_IN follows WR_ADV in order; next pointer is 0x004263.
REQ-021 Push 3 words, then FLUSH -> REQUEST with LENGTH=3; after the burst LEVEL=0 and no further REQUEST.
REQ-022 MAX_LEN=4, push 8 words -> two bursts of LENGTH=4 at consecutive addresses.
REQ-023 Pointer 0x0001FC with the macro defined, push 8 words -> LENGTH=4 then LENGTH=4 at 0x000200. Without the macro -> a single LENGTH=8 burst.
REQ-024 Pointer 0xFFFFFC, burst of 8 -> next ADDR = 0x000004.
REQ-025 Two further cases:
- RESET asserted during XFER -> next cycle REQUEST=0, LEVEL=0, ERR=0.
- WR_ADV pulsed in IDLE -> ERR=1 and LEVEL unchanged.
